// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared widths, VGA 640x480 timing constants and default pixel divide
package video_timing_pkg;
  localparam int XRES = 10;
  localparam int YRES = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int DEFAULT_PIXEL_DIVIDE = 4;
endpackage

// File: rtl/pixel_tick_divider.sv
// pixel_tick_divider: modulo-n counter; wrap is combinational, tick is its registered copy
module pixel_tick_divider #(
  parameter int N = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic wrap,
  output logic tick
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  assign wrap = cnt == W'(N - 1);
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + W'(1);
      tick <= wrap;
    end
endmodule

// File: rtl/hsync_line_timer.sv
// hsync_line_timer: pixel enable, line position counter and active-low hsync with per-line shadowed timing
module hsync_line_timer
  import video_timing_pkg::*;
#(
  parameter int xresolution = XRES,
  parameter int PixelDivide = DEFAULT_PIXEL_DIVIDE
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [xresolution-1:0] ActiveVideo,
  input  logic [xresolution-1:0] FrontPorch,
  input  logic [xresolution-1:0] SynchPulse,
  input  logic [xresolution-1:0] BackPorch,
  output logic                   PixelClock,
  output logic [xresolution-1:0] xposition,
  output logic                   hsync,
  output logic                   ActiveArea,
  output logic                   LineEnd
);
  localparam int W = xresolution + 2;
  localparam logic [W-1:0] LIM = W'(1) << xresolution;
  logic [xresolution-1:0] sh_a, sh_f, sh_s, sh_b, a_d, f_d, s_d, x_n;
  logic [W-1:0] total, last, af, afs;
  logic wrap, line_wrap;
  pixel_tick_divider #(.N(PixelDivide)) u_div (
    .CLK(CLK),
    .RESET(RESET),
    .wrap(wrap),
    .tick(PixelClock)
  );
  // Zero-length lines collapse to one pixel; oversize lines saturate at the counter range.
  assign total = W'(sh_a) + W'(sh_f) + W'(sh_s) + W'(sh_b);
  assign last = total == '0 ? '0 : total > LIM ? LIM - W'(1) : total - W'(1);
  assign line_wrap = wrap && W'(xposition) == last;
  assign x_n = line_wrap ? '0 : wrap ? xposition + xresolution'(1) : xposition;
  // The first pixel of a new line is decoded against the timing that line will use.
  assign a_d = line_wrap ? ActiveVideo : sh_a;
  assign f_d = line_wrap ? FrontPorch : sh_f;
  assign s_d = line_wrap ? SynchPulse : sh_s;
  assign af = W'(a_d) + W'(f_d);
  assign afs = af + W'(s_d);
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      sh_a <= ActiveVideo;
      sh_f <= FrontPorch;
      sh_s <= SynchPulse;
      sh_b <= BackPorch;
      xposition <= '0;
      hsync <= 1'b1;
      ActiveArea <= 1'b1;
      LineEnd <= 1'b0;
    end else begin
      xposition <= x_n;
      hsync <= !(W'(x_n) >= af && W'(x_n) < afs);
      ActiveArea <= x_n < a_d;
      LineEnd <= line_wrap;
      if (line_wrap) begin
        sh_a <= ActiveVideo;
        sh_f <= FrontPorch;
        sh_s <= SynchPulse;
        sh_b <= BackPorch;
      end
    end
endmodule

// File: tb/tb_hsync_line_timer.sv
// tb_hsync_line_timer: directed checks of line timing, shadowing, mid-line reset and degenerate config
module tb_hsync_line_timer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic [9:0] a0, f0, s0, b0, a1, f1, s1, b1, x0, x1;
  logic pc0, hs0, aa0, le0, pc1, hs1, aa1, le1;
  int total = 0, bad = 0;

  hsync_line_timer #(.xresolution(10), .PixelDivide(4)) u0 (
    .CLK(clk), .RESET(rst0), .ActiveVideo(a0), .FrontPorch(f0), .SynchPulse(s0), .BackPorch(b0),
    .PixelClock(pc0), .xposition(x0), .hsync(hs0), .ActiveArea(aa0), .LineEnd(le0)
  );
  hsync_line_timer #(.xresolution(10), .PixelDivide(1)) u1 (
    .CLK(clk), .RESET(rst1), .ActiveVideo(a1), .FrontPorch(f1), .SynchPulse(s1), .BackPorch(b1),
    .PixelClock(pc1), .xposition(x1), .hsync(hs1), .ActiveArea(aa1), .LineEnd(le1)
  );

  task automatic restart0;
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
  endtask

  task automatic test_reset;
    a0 = 640; f0 = 16; s0 = 96; b0 = 48;
    a1 = 4; f1 = 1; s1 = 2; b1 = 1;
    #2 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total += 6;
    if (x0 !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", x0); end
    if (hs0 !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", hs0); end
    if (aa0 !== 1'b1) begin bad++; $display("FAIL reset_active got=%b want=1", aa0); end
    if (pc0 !== 1'b0) begin bad++; $display("FAIL reset_pixclk got=%b want=0", pc0); end
    if (le0 !== 1'b0) begin bad++; $display("FAIL reset_lineend got=%b want=0", le0); end
    if (x1 !== 10'd0) begin bad++; $display("FAIL reset_x1 got=%0d want=0", x1); end
  endtask

  task automatic test_vga_line;
    int ex, ex_err = 0, hs_err = 0, aa_err = 0, pc_err = 0, le_err = 0, hl = 0, ah = 0, first = -1, second = -1;
    rst0 = 1'b1;
    for (int k = 1; k <= 6400; k++) begin
      @(negedge clk);
      ex = (k / 4) % 800;
      if (x0 !== 10'(ex)) ex_err++;
      if (hs0 !== !(ex >= 656 && ex < 752)) hs_err++;
      if (aa0 !== (ex < 640)) aa_err++;
      if (pc0 !== (k % 4 == 0)) pc_err++;
      if (le0 !== (k % 4 == 0 && ex == 0)) le_err++;
      if (k <= 3200 && !hs0) hl++;
      if (k <= 3200 && aa0) ah++;
      if (le0) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    total += 9;
    if (ex_err != 0) begin bad++; $display("FAIL vga_x bad_cycles=%0d want=0", ex_err); end
    if (hs_err != 0) begin bad++; $display("FAIL vga_hsync bad_cycles=%0d want=0", hs_err); end
    if (aa_err != 0) begin bad++; $display("FAIL vga_active bad_cycles=%0d want=0", aa_err); end
    if (pc_err != 0) begin bad++; $display("FAIL vga_pixclk bad_cycles=%0d want=0", pc_err); end
    if (le_err != 0) begin bad++; $display("FAIL vga_lineend bad_cycles=%0d want=0", le_err); end
    if (first != 3200) begin bad++; $display("FAIL vga_first_lineend got=%0d want=3200", first); end
    if (second - first != 3200) begin bad++; $display("FAIL vga_period got=%0d want=3200", second - first); end
    if (hl != 384) begin bad++; $display("FAIL vga_hsync_width got=%0d want=384", hl); end
    if (ah != 2560) begin bad++; $display("FAIL vga_active_width got=%0d want=2560", ah); end
  endtask

  task automatic test_small_div1;
    int ex, ex_err = 0, hs_err = 0, aa_err = 0, pc_err = 0, le_err = 0, nle = 0;
    rst1 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      ex = k % 8;
      if (x1 !== 10'(ex)) ex_err++;
      if (hs1 !== !(ex == 5 || ex == 6)) hs_err++;
      if (aa1 !== (ex < 4)) aa_err++;
      if (pc1 !== 1'b1) pc_err++;
      if (le1 !== (ex == 0)) le_err++;
      if (le1) nle++;
    end
    total += 6;
    if (ex_err != 0) begin bad++; $display("FAIL small_x bad_cycles=%0d want=0", ex_err); end
    if (hs_err != 0) begin bad++; $display("FAIL small_hsync bad_cycles=%0d want=0", hs_err); end
    if (aa_err != 0) begin bad++; $display("FAIL small_active bad_cycles=%0d want=0", aa_err); end
    if (pc_err != 0) begin bad++; $display("FAIL small_pixclk bad_cycles=%0d want=0", pc_err); end
    if (le_err != 0) begin bad++; $display("FAIL small_lineend bad_cycles=%0d want=0", le_err); end
    if (nle != 3) begin bad++; $display("FAIL small_lineend_count got=%0d want=3", nle); end
  endtask

  task automatic test_shadow;
    int ex, act, ex_err = 0, hs_err = 0, aa_err = 0, le_err = 0, hl2 = 0, first = -1;
    a0 = 640;
    restart0;
    for (int k = 1; k <= 5120; k++) begin
      @(negedge clk);
      ex = k <= 3199 ? (k / 4) % 800 : ((k - 3200) / 4) % 480;
      act = k <= 3199 ? 640 : 320;
      if (x0 !== 10'(ex)) ex_err++;
      if (hs0 !== !(ex >= act + 16 && ex < act + 112)) hs_err++;
      if (aa0 !== (ex < act)) aa_err++;
      if (le0 !== (k % 4 == 0 && ex == 0)) le_err++;
      if (k > 3200 && !hs0) hl2++;
      if (le0 && first < 0) first = k;
      if (k == 400) a0 = 320;
    end
    total += 6;
    if (ex_err != 0) begin bad++; $display("FAIL shadow_x bad_cycles=%0d want=0", ex_err); end
    if (hs_err != 0) begin bad++; $display("FAIL shadow_hsync bad_cycles=%0d want=0", hs_err); end
    if (aa_err != 0) begin bad++; $display("FAIL shadow_active bad_cycles=%0d want=0", aa_err); end
    if (le_err != 0) begin bad++; $display("FAIL shadow_lineend bad_cycles=%0d want=0", le_err); end
    if (first != 3200) begin bad++; $display("FAIL shadow_first_lineend got=%0d want=3200", first); end
    if (hl2 != 384) begin bad++; $display("FAIL shadow_new_hsync_width got=%0d want=384", hl2); end
    a0 = 640;
  endtask

  task automatic test_reset_mid;
    int early_err = 0, le_seen = 0;
    restart0;
    for (int k = 1; k <= 1600; k++) @(negedge clk);
    total += 1;
    if (x0 !== 10'd400) begin bad++; $display("FAIL mid_pre_x got=%0d want=400", x0); end
    #2 rst0 = 1'b0;
    #1;
    total += 4;
    if (x0 !== 10'd0) begin bad++; $display("FAIL mid_async_x got=%0d want=0", x0); end
    if (pc0 !== 1'b0) begin bad++; $display("FAIL mid_async_pixclk got=%b want=0", pc0); end
    if (hs0 !== 1'b1) begin bad++; $display("FAIL mid_async_hsync got=%b want=1", hs0); end
    if (aa0 !== 1'b1) begin bad++; $display("FAIL mid_async_active got=%b want=1", aa0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (le0) le_seen++;
    end
    rst0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (x0 !== 10'd0 || pc0 !== 1'b0) early_err++;
      if (le0) le_seen++;
    end
    @(negedge clk);
    total += 4;
    if (early_err != 0) begin bad++; $display("FAIL mid_early_advance bad_cycles=%0d want=0", early_err); end
    if (x0 !== 10'd1) begin bad++; $display("FAIL mid_release_x got=%0d want=1", x0); end
    if (pc0 !== 1'b1) begin bad++; $display("FAIL mid_release_pixclk got=%b want=1", pc0); end
    if (le_seen != 0) begin bad++; $display("FAIL mid_lineend got=%0d want=0", le_seen); end
  endtask

  task automatic test_zero_timing;
    int ex_err = 0, hs_err = 0, le_err = 0, nle = 0;
    a0 = 0; f0 = 0; s0 = 0; b0 = 0;
    restart0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (x0 !== 10'd0) ex_err++;
      if (hs0 !== 1'b1) hs_err++;
      if (le0 !== (k % 4 == 0) || le0 !== pc0) le_err++;
      if (le0) nle++;
    end
    total += 4;
    if (ex_err != 0) begin bad++; $display("FAIL zero_x bad_cycles=%0d want=0", ex_err); end
    if (hs_err != 0) begin bad++; $display("FAIL zero_hsync bad_cycles=%0d want=0", hs_err); end
    if (le_err != 0) begin bad++; $display("FAIL zero_lineend bad_cycles=%0d want=0", le_err); end
    if (nle != 10) begin bad++; $display("FAIL zero_lineend_count got=%0d want=10", nle); end
  endtask

  initial begin
    test_reset;
    test_vga_line;
    test_small_div1;
    test_shadow;
    test_reset_mid;
    test_zero_timing;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
